regbank_arbiter: RTL and testbench

Two-port arbiter and sequencer for a small register bank built from enable-gated D flip-flops. Two requesters share the bank. The block picks one requester, latches its address, write flag and data, and asserts exactly one register-enable for one cycle. It then returns an acknowledge and read data. It sits between bus-side requesters and the memory-structure registers and is the only driver of their enables.

---
 rtl/regbank_arbiter_if.sv | 27 ++
 rtl/regbank_arbiter.sv | 131 +++++++++++++
 tb/tb_regbank_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_arbiter_if.sv
// Bus-side bundle between the two requesters and regbank_arbiter.
// master = requester side, slave = arbiter side.
interface regbank_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic [1:0]       req;
    logic [1:0]       we;
    logic [AW-1:0]    addr0;
    logic [AW-1:0]    addr1;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic [1:0]       gnt;
    logic [1:0]       ack;
    logic [WIDTH-1:0] rdata;
    logic             busy;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1,
        input  gnt, ack, rdata, busy
    );

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1,
        output gnt, ack, rdata, busy
    );
endinterface

// File: rtl/regbank_arbiter.sv
// Two-port arbiter/sequencer owning a 2**AW x WIDTH enable-gated register bank.
// RR_ARB_EN defined: round-robin tie-break; undefined: requester 0 wins ties.
module regbank_arbiter #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              inz,
    regbank_arbiter_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACK} state_e;

    state_e           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       ack_q, ack_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [DEPTH-1:0] bank_en_q, bank_en_d;
    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [WIDTH-1:0] bank_d [DEPTH];
    logic             pick;
`ifdef RR_ARB_EN
    logic             prio_q, prio_d;
`endif

    always_comb begin
        case (bus.req)
            2'b10:   pick = 1'b1;
`ifdef RR_ARB_EN
            2'b11:   pick = prio_q;
`endif
            default: pick = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bank_en_d = '0;
`ifdef RR_ARB_EN
        prio_d    = prio_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    we_d    = bus.we[pick];
                    addr_d  = pick ? bus.addr1 : bus.addr0;
                    wdata_d = pick ? bus.wdata1 : bus.wdata0;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    // Enable is registered here so it is high for exactly the GRANT cycle.
                    bank_en_d[addr_d] = we_d;
                    busy_d  = 1'b1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!we_q) begin
                    rdata_d = bank_q[addr_q];
                end
                ack_d   = gnt_q;
                state_d = S_ACK;
            end
            S_ACK: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
`ifdef RR_ARB_EN
                prio_d  = gnt_q[0];
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bank_d = bank_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (bank_en_q[i]) begin
                bank_d[i] = wdata_q;
            end
        end
    end

    always_ff @(posedge clk or negedge inz) begin
        if (!inz) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bank_en_q <= '0;
            bank_q    <= '{default: '0};
`ifdef RR_ARB_EN
            prio_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            bank_en_q <= bank_en_d;
            bank_q    <= bank_d;
`ifdef RR_ARB_EN
            prio_q    <= prio_d;
`endif
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_regbank_arbiter.sv
// Self-checking bench for regbank_arbiter: transaction-timestamp model plus directed literals.
module tb_regbank_arbiter;
    logic clk = 1'b0;
    logic inz;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    regbank_arbiter_if #(.WIDTH(8), .AW(2)) bus ();

    regbank_arbiter #(.WIDTH(8), .AW(2)) dut (
        .clk (clk),
        .inz (inz),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Model: a transaction sampled at posedge number s shows gnt after s and s+1,
    // ack after s+1, takes effect at posedge s+1, and frees the bank at posedge s+2.
    logic [7:0] m_bank [4];
    logic [7:0] m_rdata;
    bit         m_active;
    int         m_k, m_start, m_win, m_last, m_addr;
    bit         m_we;
    logic [7:0] m_wdata;

    always @(posedge clk or negedge inz) begin
        if (!inz) begin
            for (int i = 0; i < 4; i++) m_bank[i] = 8'h00;
            m_rdata  = 8'h00;
            m_active = 1'b0;
            m_last   = 1;
            m_k      = 0;
            m_start  = 0;
        end else begin
            m_k++;
            if (m_active && m_k == m_start + 1) begin
                if (m_we) m_bank[m_addr] = m_wdata;
                else      m_rdata = m_bank[m_addr];
                m_last = m_win;
            end
            if (m_active && m_k == m_start + 2) begin
                m_active = 1'b0;
            end else if (!m_active && bus.req != 2'b00) begin
                if (bus.req == 2'b11) begin
`ifdef RR_ARB_EN
                    m_win = (m_last == 0) ? 1 : 0;
`else
                    m_win = 0;
`endif
                end else begin
                    m_win = bus.req[1] ? 1 : 0;
                end
                m_we     = bus.we[m_win];
                m_addr   = (m_win == 1) ? int'(bus.addr1) : int'(bus.addr0);
                m_wdata  = (m_win == 1) ? bus.wdata1 : bus.wdata0;
                m_start  = m_k;
                m_active = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] eg;
        eg = m_active ? ((m_win == 1) ? 2'b10 : 2'b01) : 2'b00;
        chk("gnt", bus.gnt, eg);
        chk("ack", bus.ack, (m_active && m_k == m_start + 1) ? eg : 2'b00);
        chk("busy", bus.busy, m_active);
        chk("rdata", bus.rdata, m_rdata);
        chk("bank_en", dut.bank_en_q,
            (m_active && m_k == m_start && m_we) ? (longint'(1) << m_addr) : 0);
    end

    task automatic wait_ack(input logic [1:0] mask, output logic [1:0] g, output logic [7:0] rd);
        bit got = 1'b0;
        g  = 2'b00;
        rd = 8'h00;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if ((bus.ack & mask) != 2'b00) begin
                got = 1'b1;
                g   = bus.gnt;
                rd  = bus.rdata;
            end
        end
        chk("ack_wait_bound", int'(got), 1);
    endtask

    task automatic set_fields(input int i, input bit w, input int a, input logic [7:0] d);
        bus.we[i] = w;
        if (i == 0) begin
            bus.addr0 = 2'(a);
            bus.wdata0 = d;
        end else begin
            bus.addr1 = 2'(a);
            bus.wdata1 = d;
        end
    endtask

    // Called and returns at posedge+1; drops req in the cycle after ack.
    task automatic do_req(input int i, input bit w, input int a, input logic [7:0] d,
                          output logic [7:0] rd);
        logic [1:0] g;
        logic [1:0] m;
        m = (i == 0) ? 2'b01 : 2'b10;
        set_fields(i, w, a, d);
        bus.req[i] = 1'b1;
        wait_ack(m, g, rd);
        chk("gnt_at_ack", g, m);
        @(posedge clk); #1;
        bus.req[i] = 1'b0;
    endtask

    task automatic do_reset();
        inz = 1'b0;
        @(posedge clk); #1;
        inz = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [1:0] g;
        logic [1:0] ackd;

        inz = 1'b0;
        bus.req = 2'b00;
        bus.we = 2'b00;
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
        #12;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdata", bus.rdata, 0);
        @(posedge clk); #1;
        inz = 1'b1;

        // Single write then read, with cycle-exact gnt/ack.
        @(posedge clk); #1;
        set_fields(0, 1'b1, 2, 8'hA5);
        bus.req = 2'b01;
        @(negedge clk); chk("t1_c0_gnt", bus.gnt, 2'b00);
        @(negedge clk); chk("t1_c1_gnt", bus.gnt, 2'b01); chk("t1_c1_ack", bus.ack, 2'b00);
        @(negedge clk); chk("t1_c2_ack", bus.ack, 2'b01); chk("t1_c2_gnt", bus.gnt, 2'b01);
        @(posedge clk); #1;
        bus.req = 2'b00;
        do_req(0, 1'b0, 2, 8'h00, rd);
        chk("t1_read_a5", rd, 8'hA5);

        // Both requesting, held across four transactions.
        do_reset();
        set_fields(0, 1'b1, 0, 8'h10);
        set_fields(1, 1'b1, 1, 8'h20);
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack(2'b11, g, rd);
`ifdef RR_ARB_EN
            chk("t2_rr_gnt", g, (k % 2 == 0) ? 2'b01 : 2'b10);
`else
            chk("t2_fixed_gnt", g, 2'b01);
`endif
        end
        @(posedge clk); #1;
        bus.req = 2'b00;

        // Request withdrawn and fields scrambled after sampling.
        set_fields(0, 1'b1, 1, 8'h3C);
        bus.req = 2'b01;
        @(posedge clk); #1;
        bus.req[0] = 1'b0;
        set_fields(0, 1'b0, 3, 8'hEE);
        wait_ack(2'b01, g, rd);
        chk("t3_ack_gnt", g, 2'b01);
        @(posedge clk); #1;
        do_req(0, 1'b0, 1, 8'h00, rd);
        chk("t3_read_3c", rd, 8'h3C);

        // Random traffic; requesters drop req in the cycle after their ack.
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            ackd = bus.ack;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (ackd[i]) begin
                    bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
                    set_fields(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                               8'($urandom_range(0, 255)));
                    bus.req[i] = 1'b1;
                end
            end
        end
        bus.req = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        // Reset asserted during GRANT of a write.
        set_fields(0, 1'b1, 3, 8'hFF);
        bus.req = 2'b01;
        @(posedge clk); #1;
        chk("t5_en_grant", dut.bank_en_q, 4'b1000);
        #2;
        inz = 1'b0;
        #1;
        chk("t5_rst_gnt", bus.gnt, 0);
        chk("t5_rst_ack", bus.ack, 0);
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_rdata", bus.rdata, 0);
        chk("t5_rst_en", dut.bank_en_q, 0);
        bus.req = 2'b00;
        @(posedge clk); #1;
        inz = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("t5_no_ack", bus.ack, 0);
        end
        @(posedge clk); #1;
        do_req(0, 1'b0, 3, 8'h00, rd);
        chk("t5_read_00", rd, 8'h00);

        // Cross-requester read and rdata hold across writes.
        do_req(1, 1'b1, 0, 8'h11, rd);
        do_req(0, 1'b0, 0, 8'h00, rd);
        chk("t6_read_11", rd, 8'h11);
        do_req(1, 1'b1, 0, 8'h22, rd);
        chk("t6_hold_a", bus.rdata, 8'h11);
        do_req(0, 1'b1, 1, 8'h33, rd);
        chk("t6_hold_b", bus.rdata, 8'h11);
        do_req(0, 1'b0, 0, 8'h00, rd);
        chk("t6_read_22", rd, 8'h22);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
